// File: rtl/digit_scan_mux_if.sv
// rtl/digit_scan_mux_if.sv - value/strobe inputs and scan outputs of the digit scanner
//
// Purpose: bundles the display-side signals of digit_scan_mux.
//   value_in   : packed hex value, nibble k is digit k (digit 0 least significant)
//   load       : one-cycle strobe, captures value_in into the shadow register
//   blank_lz   : enables leading-zero blanking
//   D          : hex digit currently selected, feeds segment decoders
//   digit_en   : one-hot select of the currently driven digit
//   blank      : current digit is a leading zero
//   frame_done : one-cycle pulse on the first cycle of digit 0
//   pending    : shadow holds a value not yet shown
// master: the block driving value_in/load/blank_lz; slave: the scanner itself.
interface digit_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value_in;
   logic                    load;
   logic                    blank_lz;
   logic [3:0]              D;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    blank;
   logic                    frame_done;
   logic                    pending;

   modport master (
      output value_in, load, blank_lz,
      input  D, digit_en, blank, frame_done, pending
   );

   modport slave (
      input  value_in, load, blank_lz,
      output D, digit_en, blank, frame_done, pending
   );
endinterface

// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - time-multiplexed hex digit scanner with frame-aligned commit
//
// Purpose: scans NUM_DIGITS hex digits, holding each for PRESCALE cycles. New
// values land in a shadow register and are copied to the displayed register
// only when the scan wraps from the last digit to digit 0, so a number never
// tears mid-frame.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : digit_scan_mux_if.slave (value_in/load/blank_lz in, D/digit_en/
//           blank/frame_done/pending out)
module digit_scan_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000
) (
   input  logic             clk,
   input  logic             reset,
   digit_scan_mux_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]        pre_cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] disp_reg;
   logic [4*NUM_DIGITS-1:0] shadow_reg;
   logic                    pending_r;
   logic                    frame_done_r;

   logic                    tick;
   logic                    frame_end;
   logic [3:0]              d_c;
   logic                    lz_c;
   logic                    upper_zero;

   assign tick      = (pre_cnt == PRE_LAST);
   assign frame_end = tick && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt      <= '0;
         idx          <= '0;
         disp_reg     <= '0;
         shadow_reg   <= '0;
         pending_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         if (tick)
            pre_cnt <= '0;
         else
            pre_cnt <= pre_cnt + 1'b1;

         // Explicit wrap keeps idx in range for non-power-of-two digit counts.
         if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

         frame_done_r <= frame_end;

         if (frame_end && pending_r)
            disp_reg <= shadow_reg;

         // A load coinciding with the commit wins the pending flag: the old
         // shadow goes to display while the new value waits for the next frame.
         if (bus.load) begin
            shadow_reg <= bus.value_in;
            pending_r  <= 1'b1;
         end else if (frame_end) begin
            pending_r  <= 1'b0;
         end
      end
   end

   // Walk from the most significant digit down, accumulating "everything at
   // and above this digit is zero", and pick out the entry for idx.
   always_comb begin
      d_c        = 4'h0;
      lz_c       = 1'b0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero & (disp_reg[4*k +: 4] == 4'h0);
         if (idx == IDX_W'(k)) begin
            d_c  = disp_reg[4*k +: 4];
            lz_c = upper_zero;
         end
      end
   end

   assign bus.D          = d_c;
   assign bus.digit_en   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
   assign bus.blank      = bus.blank_lz & (idx != '0) & lz_c;
   assign bus.frame_done = frame_done_r;
   assign bus.pending    = pending_r;
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb/tb_digit_scan_mux.sv - self-checking bench for digit_scan_mux
module tb_digit_scan_mux;
   logic clk = 1'b0;
   logic reset;
   logic reset2;

   int n_total = 0;
   int n_pass  = 0;

   digit_scan_mux_if #(.NUM_DIGITS(4)) b1 ();
   digit_scan_mux_if #(.NUM_DIGITS(3)) b2 ();

   digit_scan_mux #(.NUM_DIGITS(4), .PRESCALE(4)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   digit_scan_mux #(.NUM_DIGITS(3), .PRESCALE(1)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (b2.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model of instance 1: time since reset decides which digit is shown;
   // the display value changes only at multiples of a 16-cycle frame.
   int          mt = 0;
   bit          m_valid = 0;
   logic [15:0] m_disp, m_shadow;
   bit          m_pend;

   always @(posedge clk) begin
      if (reset) begin
         mt = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_valid = 1;
      end else if (m_valid) begin
         if ((mt % 16) == 15 && m_pend) begin
            m_disp = m_shadow;
            m_pend = 0;
         end
         if (b1.load) begin
            m_shadow = b1.value_in;
            m_pend   = 1;
         end
         mt++;
      end
   end

   // Model of instance 2: one digit per cycle over three digits, value 0.
   int t2 = 0;
   bit v2 = 0;
   always @(posedge clk) begin
      if (reset2) begin
         t2 = 0; v2 = 1;
      end else if (v2) begin
         t2++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         int digit;
         logic [15:0] upper;
         digit = (mt / 4) % 4;
         upper = m_disp >> (4 * digit);
         check("m_D", 32'(b1.D), 32'(upper & 16'hF));
         check("m_digit_en", 32'(b1.digit_en), 32'(1) << digit);
         check("m_blank", 32'(b1.blank), 32'(b1.blank_lz && digit != 0 && upper == 0));
         check("m_frame_done", 32'(b1.frame_done), 32'(mt > 0 && (mt % 16) == 0));
         check("m_pending", 32'(b1.pending), 32'(m_pend));
      end
      if (v2) begin
         check("m2_digit_en", 32'(b2.digit_en), 32'(1) << (t2 % 3));
         check("m2_frame_done", 32'(b2.frame_done), 32'(t2 > 0 && (t2 % 3) == 0));
         check("m2_D", 32'(b2.D), 32'h0);
         check("m2_pending", 32'(b2.pending), 32'h0);
      end
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_state(input int s);
      int guard = 0;
      while (mt != s && guard < 2000) begin
         adv(1);
         guard++;
      end
      if (mt != s)
         check("wait_state_timeout", 32'(mt), 32'(s));
   endtask

   task automatic neg_at(input int s);
      wait_state(s);
      @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v);
      b1.value_in = v;
      b1.load     = 1'b1;
      adv(1);
      b1.load     = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      adv(n);
      reset = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fd_cnt, bad;
      reset = 1'b1; reset2 = 1'b1;
      b1.value_in = '0; b1.load = 1'b0; b1.blank_lz = 1'b0;
      b2.value_in = '0; b2.load = 1'b0; b2.blank_lz = 1'b0;
      adv(2);
      @(negedge clk);
      check("rst_D", 32'(b1.D), 32'h0);
      check("rst_digit_en", 32'(b1.digit_en), 32'h1);
      check("rst_blank", 32'(b1.blank), 32'h0);
      check("rst_frame_done", 32'(b1.frame_done), 32'h0);
      check("rst_pending", 32'(b1.pending), 32'h0);
      reset = 1'b0; reset2 = 1'b0;

      // Instance 2: digit sequence 0,1,2,0 with wrap pulse on the return to 0.
      check("p1_en_s0", 32'(b2.digit_en), 32'b001);
      @(negedge clk); check("p1_en_s1", 32'(b2.digit_en), 32'b010);
      @(negedge clk); check("p1_en_s2", 32'(b2.digit_en), 32'b100);
      @(negedge clk); check("p1_en_s3", 32'(b2.digit_en), 32'b001);
      check("p1_fd_s3", 32'(b2.frame_done), 32'h1);

      // Load then reset mid-scan: the pending value must be discarded.
      do_load(16'hFFFF);
      adv(2);
      do_reset(3);
      @(negedge clk);
      check("mid_rst_D", 32'(b1.D), 32'h0);
      check("mid_rst_en", 32'(b1.digit_en), 32'h1);
      check("mid_rst_blank", 32'(b1.blank), 32'h0);
      check("mid_rst_fd", 32'(b1.frame_done), 32'h0);
      check("mid_rst_pending", 32'(b1.pending), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("hold_digit0", 32'(b1.digit_en), (i < 4) ? 32'h1 : 32'h2);
      end
      neg_at(16);
      check("discard_D", 32'(b1.D), 32'h0);

      // Load at cycle 2, commit on the frame wrap into cycle 16.
      do_reset(1);
      wait_state(2);
      do_load(16'h1A3F);
      @(negedge clk);
      check("ld_pending", 32'(b1.pending), 32'h1);
      check("ld_D_hold", 32'(b1.D), 32'h0);
      neg_at(15); check("ld_D_15", 32'(b1.D), 32'h0);
      neg_at(16);
      check("ld_D_16", 32'(b1.D), 32'hF);
      check("ld_en_16", 32'(b1.digit_en), 32'h1);
      check("ld_pending_16", 32'(b1.pending), 32'h0);
      check("ld_fd_16", 32'(b1.frame_done), 32'h1);
      neg_at(20); check("ld_D_20", 32'(b1.D), 32'h3); check("ld_en_20", 32'(b1.digit_en), 32'h2);
      neg_at(24); check("ld_D_24", 32'(b1.D), 32'hA); check("ld_en_24", 32'(b1.digit_en), 32'h4);
      neg_at(28); check("ld_D_28", 32'(b1.D), 32'h1); check("ld_en_28", 32'(b1.digit_en), 32'h8);

      // Leading-zero blanking.
      b1.blank_lz = 1'b1;
      wait_state(33);
      do_load(16'h0050);
      neg_at(48); check("lz50_d0", 32'(b1.blank), 32'h0);
      neg_at(52); check("lz50_d1", 32'(b1.blank), 32'h0); check("lz50_D1", 32'(b1.D), 32'h5);
      neg_at(56); check("lz50_d2", 32'(b1.blank), 32'h1);
      neg_at(60); check("lz50_d3", 32'(b1.blank), 32'h1);
      b1.blank_lz = 1'b0;
      #1 check("lz_off_comb", 32'(b1.blank), 32'h0);
      b1.blank_lz = 1'b1;
      wait_state(65);
      do_load(16'h0000);
      neg_at(80); check("lz00_d0", 32'(b1.blank), 32'h0);
      neg_at(84); check("lz00_d1", 32'(b1.blank), 32'h1);
      neg_at(92); check("lz00_d3", 32'(b1.blank), 32'h1);
      wait_state(97);
      do_load(16'h5007);
      neg_at(116); check("lz5007_d1", 32'(b1.blank), 32'h0); check("lz5007_D1", 32'(b1.D), 32'h0);
      neg_at(120); check("lz5007_d2", 32'(b1.blank), 32'h0);

      // Load on the frame_end cycle while a value is pending.
      wait_state(130);
      do_load(16'h1111);
      wait_state(143);
      do_load(16'h2222);
      neg_at(144); check("col_D_144", 32'(b1.D), 32'h1); check("col_pend_144", 32'(b1.pending), 32'h1);
      neg_at(156); check("col_D_156", 32'(b1.D), 32'h1);
      neg_at(160); check("col_D_160", 32'(b1.D), 32'h2); check("col_pend_160", 32'(b1.pending), 32'h0);
      neg_at(172); check("col_D_172", 32'(b1.D), 32'h2);

      // Free run: frame_done once per 16 cycles, only with digit 0 selected.
      fd_cnt = 0; bad = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (b1.frame_done) begin
            fd_cnt++;
            if (b1.digit_en != 4'b0001) bad++;
         end
         if (!$onehot(b1.digit_en)) bad++;
      end
      check("run_fd_count", 32'(fd_cnt), 32'd4);
      check("run_bad", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
